mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Round-robin controller that shares one combinational 8x8 array multiplier among `NREQ` requesters. Each requester offers an operand pair with a valid/ready handshake. The block registers the granted operands onto the multiplier inputs and waits a fixed number of cycles for the array to settle. It then captures the 16-bit product and returns it with the requester's index on a single backpressured response channel. The block sits between client logic and the multiplier instance; the multiplier itself is external and connected through `mul_a`, `mul_b` and `mul_p`.

## Interface
- `NREQ`, default 4: number of requesters. Legal range 2..8.
- `MUL_CYCLES`, default 2: clock cycles allowed for the multiplier to settle. Must be ≥1; 0 is illegal.
- `IDW`, default `$clog2(NREQ)`: width of the requester id. Minimum 1.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: active-low asynchronous reset.
- One clock; reset is asynchronous and active-low.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept. One-hot or zero.
- `req_a` in 8*NREQ: operand A. Requester i uses bits [8i+7:8i].
- `req_b` in 8*NREQ: operand B, same packing as `req_a`.
- `mul_a` out 8: registered operand to the multiplier.
- `mul_b` out 8: registered operand to the multiplier.
- `mul_p` in 16: product returned from the multiplier.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_p` out 16: product.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, CALC, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, grant index g: the first set bit found searching upward from `ptr`, wrapping modulo NREQ.
  - `req_ready[g]` is driven combinationally in IDLE only.
  - On the handshake edge: `mul_a`←A[g], `mul_b`←B[g], `rsp_id`←g, `ptr`←(g+1) mod NREQ, `cnt`←MUL_CYCLES−1; go to CALC.
- **CALC:**
  - If `cnt`==0: `rsp_p`←`mul_p`, `rsp_valid`←1, go to RESP.
  - Otherwise decrement `cnt`.
- **RESP:**
  - `rsp_valid`, `rsp_id` and `rsp_p` hold stable until `rsp_ready`=1.
  - On that edge `rsp_valid`←0 and the FSM goes to IDLE.
- **Operand hold:** `mul_a` and `mul_b` keep their value between operations; they change only on a grant.
- **Withdrawal:** a requester may drop `req_valid` before its handshake. Nothing is latched for it and `ptr` is unchanged.
- **Grant exclusivity:** `req_ready` is all-zero in CALC and RESP, and all-zero while `rst_n`=0.
- **Arithmetic:** `rsp_p` is the unsigned product exactly as delivered on `mul_p`. No truncation; e.g. 0xFF×0xFF=0xFE01.
- **Reset (asynchronous, any state):**
  - State←IDLE, `ptr`←0, `cnt`←0.
  - `mul_a`, `mul_b`←0; `rsp_p`←0; `rsp_id`←0; `rsp_valid`←0; `busy`←0.
  - An operation in flight is discarded; no response is ever issued for it.

## Timing
- Request accepted at edge E0. `mul_a`/`mul_b` are valid from E0.
- `rsp_valid` rises at edge E0+MUL_CYCLES, and `rsp_p` is captured at that same edge.
- Response handshake at edge Er ≥ E0+MUL_CYCLES. State is IDLE after Er, so the next grant is possible at edge Er+1 at the earliest.
- Peak throughput is one product per MUL_CYCLES+2 cycles when `rsp_ready` is held high.
- `busy` rises after E0 and falls after Er.
- Simultaneous requests: exactly one grant per IDLE cycle. Requests not granted must hold `req_valid` and operands until their own handshake.
- `ptr` advances only on a grant; it wraps from NREQ−1 to 0.

## Test plan
- **Single request, NREQ=4, MUL_CYCLES=2:** req0 presents A=3, B=5. Expect `req_ready[0]` high in IDLE, then `rsp_valid` 2 edges after accept with `rsp_p`=0x000F and `rsp_id`=0. `busy` is high from accept through the response handshake.
- **Width check:** req3 presents 0xFF×0xFF, then 0x80×0x02. Expect `rsp_p`=0xFE01 with id 3, then 0x0100 with id 3.
- **Fairness:** all four `req_valid` held high, `rsp_ready`=1. Expect grant order 0,1,2,3,0. Each response carries the matching id. Grants are spaced MUL_CYCLES+2 cycles apart.
- **Two competing requesters:** req0 and req2 continuously valid. Expect alternating grants 0,2,0,2; req0 is never granted twice in a row.
- **Backpressure:** `rsp_ready` held low for 5 cycles after `rsp_valid` rises. Expect `rsp_valid`/`rsp_p`/`rsp_id` stable and `req_ready` all zero during the stall. After `rsp_ready` rises, the next grant comes one cycle later.
- **Reset mid-CALC:** pulse `rst_n` low one cycle after an accept. Expect all outputs at reset values immediately, no `rsp_valid` for the aborted op, and `ptr`=0 (the next grant goes to the lowest valid index).

Source files
------------

// File: rtl/mult_share_ctrl_if.sv
// Bundle of requester, multiplier and response signals for mult_share_ctrl.
// The controller connects through the slave modport and its environment through the master modport.
interface mult_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_p;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter sharing one external combinational 8x8 multiplier among NREQ requesters.
// Operands are registered onto the array, allowed MUL_CYCLES to settle, then the product is returned.
module mult_share_ctrl #(
  parameter int NREQ       = 4,
  parameter int MUL_CYCLES = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_share_ctrl_if.slave  bus
);

  localparam int CNTW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MUL_CYCLES - 1);
  localparam logic [IDW-1:0]  LAST_IDX = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [CNTW-1:0] cnt_q;
  logic [7:0]      mul_a_q;
  logic [7:0]      mul_b_q;
  logic [15:0]     rsp_p_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_valid_q;
  logic            busy_q;

  logic            grant_vld_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [NREQ-1:0] req_ready_s;
  logic [7:0]      op_a_s;
  logic [7:0]      op_b_s;

  // Returns {found, index} of the first valid requester at or above ptr, wrapping modulo NREQ.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] ptr);
    logic [IDW:0]   pick;
    logic [IDW-1:0] sel;
    int             idx;
    pick = {(IDW+1){1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      sel = IDW'(idx);
      if (valid[sel]) begin
        pick = {1'b1, sel};
      end
    end
    return pick;
  endfunction

  // Grant selection, operand mux and combinational accept; accept is gated by reset and IDLE.
  always_comb begin
    {grant_vld_s, grant_idx_s} = rr_pick(bus.req_valid, ptr_q);
    op_a_s      = bus.req_a[{grant_idx_s, 3'b000} +: 8];
    op_b_s      = bus.req_b[{grant_idx_s, 3'b000} +: 8];
    req_ready_s = {NREQ{1'b0}};
    if (grant_idx_s == LAST_IDX) begin
      ptr_d = {IDW{1'b0}};
    end else begin
      ptr_d = grant_idx_s + IDW'(1);
    end
    if (rst_n && (state_q == ST_IDLE) && grant_vld_s) begin
      req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
  end

  // Control sequencer: grant in IDLE, settle countdown in CALC, hold response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {IDW{1'b0}};
      cnt_q       <= {CNTW{1'b0}};
      mul_a_q     <= 8'h00;
      mul_b_q     <= 8'h00;
      rsp_p_q     <= 16'h0000;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_s) begin
            mul_a_q  <= op_a_s;
            mul_b_q  <= op_b_s;
            rsp_id_q <= grant_idx_s;
            ptr_q    <= ptr_d;
            cnt_q    <= CNT_LOAD;
            busy_q   <= 1'b1;
            state_q  <= ST_CALC;
          end
        end
        ST_CALC: begin
          // The array has had MUL_CYCLES edges to settle once the count reaches zero.
          if (cnt_q == {CNTW{1'b0}}) begin
            rsp_p_q     <= bus.mul_p;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: a settling multiplier model, a transaction-level scoreboard,
// a table of single-request vectors, directed arbitration/backpressure/reset sequences and random traffic.
module tb_mult_share_ctrl;
  localparam int NREQ = 4;
  localparam int MC   = 2;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) tif ();

  mult_share_ctrl #(.NREQ(NREQ), .MUL_CYCLES(MC), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier model: reads garbage until the operands have been stable for MC-1 falling edges.
  int         age = 0;
  logic [7:0] last_a;
  logic [7:0] last_b;
  always @(negedge clk) begin
    if (tif.mul_a !== last_a || tif.mul_b !== last_b) age = 0;
    else if (age < 100) age++;
    last_a = tif.mul_a;
    last_b = tif.mul_b;
    tif.mul_p = (age >= MC - 1) ? ({8'd0, tif.mul_a} * {8'd0, tif.mul_b}) : 16'hDEAD;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Transaction-level reference: who should be granted, and when/what the response must be.
  logic            m_busy = 1'b0;
  int              mptr = 0;
  int              m_id, m_e0, g, n;
  logic [7:0]      m_a = 8'h00;
  logic [7:0]      m_b = 8'h00;
  logic [15:0]     m_prod;
  logic [NREQ-1:0] exp_rdy;
  int              g_log[$];
  int              g_cyc[$];

  function automatic logic [NREQ-1:0] rr_expect(input logic [NREQ-1:0] v, input int p);
    logic [2*NREQ-1:0] dbl;
    dbl = {v, v} >> p;
    for (int j = 0; j < NREQ; j++)
      if (dbl[j]) return NREQ'(1) << ((p + j) % NREQ);
    return '0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(tif.req_ready), 32'd0);
      chk("rst_busy", 32'(tif.busy), 32'd0);
      chk("rst_rsp_valid", 32'(tif.rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(tif.rsp_id), 32'd0);
      chk("rst_rsp_p", 32'(tif.rsp_p), 32'd0);
      chk("rst_mul_a", 32'(tif.mul_a), 32'd0);
      chk("rst_mul_b", 32'(tif.mul_b), 32'd0);
      mptr = 0; m_busy = 1'b0; m_a = 8'h00; m_b = 8'h00;
    end else if (!m_busy) begin
      exp_rdy = rr_expect(tif.req_valid, mptr);
      chk("idle_req_ready", 32'(tif.req_ready), 32'(exp_rdy));
      chk("idle_busy", 32'(tif.busy), 32'd0);
      chk("idle_rsp_valid", 32'(tif.rsp_valid), 32'd0);
      chk("hold_mul_a", 32'(tif.mul_a), 32'(m_a));
      chk("hold_mul_b", 32'(tif.mul_b), 32'(m_b));
      if (exp_rdy != '0) begin
        for (int j = 0; j < NREQ; j++) if (exp_rdy[j]) g = j;
        m_a    = tif.req_a[8*g +: 8];
        m_b    = tif.req_b[8*g +: 8];
        m_prod = 16'(m_a) * 16'(m_b);
        m_id   = g;
        m_e0   = cyc + 1;
        mptr   = (g + 1) % NREQ;
        m_busy = 1'b1;
        g_log.push_back(g);
        g_cyc.push_back(cyc + 1);
      end
    end else begin
      n = cyc - m_e0;
      chk("busy_req_ready", 32'(tif.req_ready), 32'd0);
      chk("busy_flag", 32'(tif.busy), 32'd1);
      chk("op_mul_a", 32'(tif.mul_a), 32'(m_a));
      chk("op_mul_b", 32'(tif.mul_b), 32'(m_b));
      chk("rsp_valid_timing", 32'(tif.rsp_valid), 32'(n >= MC));
      if (n >= MC) begin
        chk("rsp_p", 32'(tif.rsp_p), 32'(m_prod));
        chk("rsp_id", 32'(tif.rsp_id), 32'(m_id));
        if (tif.rsp_ready) m_busy = 1'b0;
      end
    end
  end

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    @(negedge clk);
    while (!tif.rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!tif.rsp_valid) chk("timeout_rsp", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((tif.busy || m_busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (tif.busy || m_busy) chk("timeout_idle", 32'd0, 32'd1);
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    tif.req_a[8*id +: 8] = a;
    tif.req_b[8*id +: 8] = b;
    tif.req_valid[id]    = 1'b1;
  endtask

  task automatic run_single(input vec_t v);
    int k;
    tick();
    tif.req_valid = '0;
    set_req(v.id, v.a, v.b);
    @(negedge clk);
    chk("single_ready", 32'(tif.req_ready), 32'(NREQ'(1) << v.id));
    tick();
    tif.req_valid[v.id] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!tif.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("single_latency", 32'(k), 32'(MC));
    chk("single_rsp_p", 32'(tif.rsp_p), 32'(v.p));
    chk("single_rsp_id", 32'(tif.rsp_id), 32'(v.id));
    chk("single_busy", 32'(tif.busy), 32'd1);
    @(negedge clk);
    chk("single_done_valid", 32'(tif.rsp_valid), 32'd0);
    chk("single_done_busy", 32'(tif.busy), 32'd0);
  endtask

  function automatic logic [7:0] rnd_op();
    return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  int              exp_fair[5] = '{0, 1, 2, 3, 0};
  logic [15:0]     hold_p;
  logic [IDW-1:0]  hold_id;
  logic [NREQ-1:0] hs;
  int              k;

  initial begin
    tbl[0] = '{0, 8'h03, 8'h05, 16'h000F};
    tbl[1] = '{3, 8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{3, 8'h80, 8'h02, 16'h0100};
    tbl[3] = '{2, 8'h12, 8'h34, 16'h03A8};
    tbl[4] = '{1, 8'h00, 8'hAB, 16'h0000};
    tbl[5] = '{1, 8'hFF, 8'h01, 16'h00FF};

    rst_n = 1'b0;
    tif.req_valid = '0; tif.req_a = '0; tif.req_b = '0; tif.rsp_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tif.rsp_ready = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_single(tbl[i]);

    // Fairness from a fresh pointer: all four requesters held valid.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    g_log.delete(); g_cyc.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), 8'h03);
    k = 0;
    while (g_log.size() < 5 && k < 100) begin @(negedge clk); k++; end
    chk("fair_count", 32'(g_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < g_log.size(); i++) begin
      chk("fair_order", 32'(g_log[i]), 32'(exp_fair[i]));
      if (i > 0) chk("fair_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(MC + 2));
    end
    tick(); tif.req_valid = '0;
    wait_idle();

    // Two competitors must alternate.
    g_log.delete();
    tick();
    set_req(0, 8'h07, 8'h09);
    set_req(2, 8'h21, 8'h11);
    k = 0;
    while (g_log.size() < 4 && k < 100) begin @(negedge clk); k++; end
    tick(); tif.req_valid = '0;
    wait_idle();
    chk("alt_count", 32'(g_log.size() >= 4), 32'd1);
    for (int i = 0; i < g_log.size(); i++) begin
      chk("alt_member", 32'(g_log[i] == 0 || g_log[i] == 2), 32'd1);
      if (i > 0) chk("alt_no_repeat", 32'(g_log[i] != g_log[i-1]), 32'd1);
    end

    // Backpressure: response stalled 5 cycles while another requester waits.
    tick();
    tif.rsp_ready = 1'b0;
    set_req(1, 8'h0C, 8'h0D);
    @(negedge clk);
    chk("bp_grant", 32'(tif.req_ready), 32'h2);
    tick();
    tif.req_valid = '0;
    set_req(2, 8'h40, 8'h04);
    wait_rsp();
    hold_p = tif.rsp_p; hold_id = tif.rsp_id;
    chk("bp_first_p", 32'(hold_p), 32'h009C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stall_valid", 32'(tif.rsp_valid), 32'd1);
      chk("bp_stall_p", 32'(tif.rsp_p), 32'(hold_p));
      chk("bp_stall_id", 32'(tif.rsp_id), 32'(hold_id));
      chk("bp_stall_ready", 32'(tif.req_ready), 32'd0);
    end
    tick(); tif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_before_hs", 32'(tif.req_ready), 32'd0);
    @(negedge clk);
    chk("bp_next_grant", 32'(tif.req_ready), 32'h4);
    tick(); tif.req_valid = '0;
    wait_idle();

    // Reset one cycle after an accept discards the operation and clears the pointer.
    tick();
    set_req(1, 8'h0B, 8'h0B);
    set_req(3, 8'h33, 8'h02);
    k = 0;
    @(negedge clk);
    while (tif.req_ready == '0 && k < 20) begin @(negedge clk); k++; end
    tick();
    tick(); rst_n = 1'b0;
    @(negedge clk);
    chk("rstcalc_valid", 32'(tif.rsp_valid), 32'd0);
    chk("rstcalc_busy", 32'(tif.busy), 32'd0);
    chk("rstcalc_ready", 32'(tif.req_ready), 32'd0);
    chk("rstcalc_mul_a", 32'(tif.mul_a), 32'd0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rstcalc_regrant", 32'(tif.req_ready), 32'h2);
    tick(); tif.req_valid = '0;
    wait_rsp();
    chk("rstcalc_rsp_id", 32'(tif.rsp_id), 32'd1);
    chk("rstcalc_rsp_p", 32'(tif.rsp_p), 32'h0079);
    wait_idle();

    // Random traffic with withdrawals, backpressure and occasional resets.
    hs = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      tif.rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] || (!tif.req_valid[i] && $urandom_range(0, 2) == 0)) begin
          tif.req_valid[i]    = hs[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          tif.req_a[8*i +: 8] = rnd_op();
          tif.req_b[8*i +: 8] = rnd_op();
        end else if (tif.req_valid[i] && $urandom_range(0, 19) == 0) begin
          tif.req_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
      hs = tif.req_ready & tif.req_valid;
    end
    tick();
    rst_n = 1'b1; tif.rsp_ready = 1'b1; tif.req_valid = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
